sync_fifo_pro: RTL and testbench

Parametrised single-clock FIFO, successor to the basic synchronous FIFO. Adds a compile-time first-word-fall-through (FWFT) or standard read mode, any depth including non-power-of-two, and run-time programmable almost-full/almost-empty thresholds. Overflow/underflow are sticky error flags with explicit clear. Sits between any two same-clock producer/consumer stages in the datapath.

---
 rtl/sync_fifo_pro.sv | 133 +++++++++++++
 tb/tb_sync_fifo_pro.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_pro.sv
// ============================================================================
// sync_fifo_pro : single-clock FIFO, FWFT/standard read, any depth, sticky errors
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_fifo_pro #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int FWFT  = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_WR_EN,
  input  logic [WIDTH-1:0] i_WR_DATA,
  input  logic             i_RD_EN,
  output logic [WIDTH-1:0] o_RD_DATA,
  output logic             o_VALID,
  output logic             o_FULL,
  output logic             o_EMPTY,
  input  logic [CNT_W-1:0] i_AF_THRESH,
  input  logic [CNT_W-1:0] i_AE_THRESH,
  output logic             o_ALMOST_FULL,
  output logic             o_ALMOST_EMPTY,
  output logic [CNT_W-1:0] o_COUNT,
  input  logic             i_CLR_ERR,
  output logic             o_OVERFLOW,
  output logic             o_UNDERFLOW
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic full, empty, wr_acc, rd_acc;

  always_comb begin
    full   = (count_q == FULL_CNT);
    empty  = (count_q == '0);
    wr_acc = i_WR_EN & ~full;
    rd_acc = i_RD_EN & ~empty;

    // Explicit wrap so non-power-of-two depths never index past DEPTH-1
    wr_ptr_d = wr_ptr_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    rd_ptr_d = rd_ptr_q;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear
    ovf_d = (i_WR_EN & full)  | (ovf_q & ~i_CLR_ERR);
    udf_d = (i_RD_EN & empty) | (udf_q & ~i_CLR_ERR);
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_WR_DATA;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented combinationally; zero while empty
      assign o_RD_DATA = empty ? '0 : mem_q[rd_ptr_q];
      assign o_VALID   = ~empty;
    end else begin : g_std
      logic [WIDTH-1:0] rd_data_q, rd_data_d;
      logic             valid_q, valid_d;

      always_comb begin
        rd_data_d = rd_data_q;
        valid_d   = 1'b0;
        if (rd_acc) begin
          rd_data_d = mem_q[rd_ptr_q];
          valid_d   = 1'b1;
        end
      end

      always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
          rd_data_q <= '0;
          valid_q   <= 1'b0;
        end else begin
          rd_data_q <= rd_data_d;
          valid_q   <= valid_d;
        end
      end

      assign o_RD_DATA = rd_data_q;
      assign o_VALID   = valid_q;
    end
  endgenerate

  assign o_COUNT        = count_q;
  assign o_FULL         = full;
  assign o_EMPTY        = empty;
  assign o_ALMOST_FULL  = (count_q >= i_AF_THRESH);
  assign o_ALMOST_EMPTY = (count_q <= i_AE_THRESH);
  assign o_OVERFLOW     = ovf_q;
  assign o_UNDERFLOW    = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_pro.sv
// ============================================================================
// tb_sync_fifo_pro : two FIFO instances (standard depth 32, FWFT depth 5)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_pro;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wr_en = 1'b0, rd_en = 1'b0, clr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [5:0] af0 = 6'd30, ae0 = 6'd2;
  logic [2:0] af1 = 3'd4,  ae1 = 3'd1;

  logic [7:0] s_rd, f_rd;
  logic [5:0] s_count;
  logic [2:0] f_count;
  logic s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;

  sync_fifo_pro #(.WIDTH(8), .DEPTH(32), .FWFT(0)) u_std (
    .i_CLK(clk), .i_RESET(rst), .i_WR_EN(wr_en), .i_WR_DATA(wdata),
    .i_RD_EN(rd_en), .o_RD_DATA(s_rd), .o_VALID(s_valid), .o_FULL(s_full),
    .o_EMPTY(s_empty), .i_AF_THRESH(af0), .i_AE_THRESH(ae0),
    .o_ALMOST_FULL(s_af), .o_ALMOST_EMPTY(s_ae), .o_COUNT(s_count),
    .i_CLR_ERR(clr), .o_OVERFLOW(s_ovf), .o_UNDERFLOW(s_udf)
  );

  sync_fifo_pro #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_fwft (
    .i_CLK(clk), .i_RESET(rst), .i_WR_EN(wr_en), .i_WR_DATA(wdata),
    .i_RD_EN(rd_en), .o_RD_DATA(f_rd), .o_VALID(f_valid), .o_FULL(f_full),
    .o_EMPTY(f_empty), .i_AF_THRESH(af1), .i_AE_THRESH(ae1),
    .o_ALMOST_FULL(f_af), .o_ALMOST_EMPTY(f_ae), .o_COUNT(f_count),
    .i_CLR_ERR(clr), .o_OVERFLOW(f_ovf), .o_UNDERFLOW(f_udf)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: total pushes/pops per instance, data kept by push index
  int         dep [2] = '{32, 5};
  int         wt [2], rt [2];
  logic [7:0] mm [2][64];
  bit         ovf_m [2], udf_m [2], vld_m [2];
  logic [7:0] rd_m [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      wt[k] = 0; rt[k] = 0;
      ovf_m[k] = 0; udf_m[k] = 0; vld_m[k] = 0;
      rd_m[k] = 8'h00;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int c;
      bit is_full, is_empty, wa, ra;
      c        = wt[k] - rt[k];
      is_full  = (c == dep[k]);
      is_empty = (c == 0);
      wa       = wr_en && !is_full;
      ra       = rd_en && !is_empty;
      vld_m[k] = 0;
      if (ra) begin
        rd_m[k]  = mm[k][rt[k] % 64];
        vld_m[k] = 1;
        rt[k]++;
      end
      if (wa) begin
        mm[k][wt[k] % 64] = wdata;
        wt[k]++;
      end
      ovf_m[k] = (wr_en && is_full)  || (ovf_m[k] && !clr);
      udf_m[k] = (rd_en && is_empty) || (udf_m[k] && !clr);
    end
  endtask

  task automatic check_all();
    int c;
    c = wt[0] - rt[0];
    check_eq("s_count", 32'(s_count), 32'(c));
    check_eq("s_full",  32'(s_full),  32'(c == 32));
    check_eq("s_empty", 32'(s_empty), 32'(c == 0));
    check_eq("s_af",    32'(s_af),    32'(c >= int'(af0)));
    check_eq("s_ae",    32'(s_ae),    32'(c <= int'(ae0)));
    check_eq("s_ovf",   32'(s_ovf),   32'(ovf_m[0]));
    check_eq("s_udf",   32'(s_udf),   32'(udf_m[0]));
    check_eq("s_valid", 32'(s_valid), 32'(vld_m[0]));
    check_eq("s_rd",    32'(s_rd),    32'(rd_m[0]));
    c = wt[1] - rt[1];
    check_eq("f_count", 32'(f_count), 32'(c));
    check_eq("f_full",  32'(f_full),  32'(c == 5));
    check_eq("f_empty", 32'(f_empty), 32'(c == 0));
    check_eq("f_af",    32'(f_af),    32'(c >= int'(af1)));
    check_eq("f_ae",    32'(f_ae),    32'(c <= int'(ae1)));
    check_eq("f_ovf",   32'(f_ovf),   32'(ovf_m[1]));
    check_eq("f_udf",   32'(f_udf),   32'(udf_m[1]));
    check_eq("f_valid", 32'(f_valid), 32'(c != 0));
    if (c != 0) check_eq("f_rd", 32'(f_rd), 32'(mm[1][rt[1] % 64]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input bit w, input bit r, input logic [7:0] d);
    wr_en = w;
    rd_en = r;
    wdata = d;
  endtask

  initial begin
    model_reset();
    tick();
    check_eq("rst_s_rd", 32'(s_rd), 32'h0);
    check_eq("rst_f_rd", 32'(f_rd), 32'h0);
    rst = 1'b0;

    // Fill 0x00..0x1F plus one overflowing write, then clear errors
    for (int i = 0; i < 33; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      tick();
      if (i == 29) check_eq("af_after_30", 32'(s_af), 32'h1);
      if (i == 2)  check_eq("ae_after_3",  32'(s_ae), 32'h0);
    end
    check_eq("fill_full",  32'(s_full),  32'h1);
    check_eq("fill_ovf",   32'(s_ovf),   32'h1);
    check_eq("fill_count", 32'(s_count), 32'd32);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    check_eq("ovf_sticky", 32'(s_ovf), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Drain in order, last read underflows
    for (int i = 0; i < 33; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      tick();
      if (i < 32) check_eq("drain_data", 32'(s_rd), 32'(i));
    end
    check_eq("drain_udf", 32'(s_udf), 32'h1);
    drive(1'b0, 1'b0, 8'h00);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Wrap-around: three rounds of write 4 / read 4
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 8'($urandom)); tick(); end
      for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1, 8'h00); tick(); end
    end

    // Simultaneous read/write at count 3
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 8'($urandom)); tick(); end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 8'($urandom));
      tick();
      check_eq("simul_count", 32'(f_count), 32'd3);
    end
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1, 8'h00); tick(); end

    // FWFT latency with a single word
    drive(1'b1, 1'b0, 8'hA5);
    tick();
    check_eq("fwft_valid", 32'(f_valid), 32'h1);
    check_eq("fwft_data",  32'(f_rd),    32'hA5);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b1, 8'h00);
    tick();
    check_eq("fwft_pop_empty", 32'(f_empty), 32'h1);

    // Randomised traffic with biased phases and live threshold changes
    for (int i = 0; i < 800; i++) begin
      int wp;
      wp = (i < 400) ? 70 : 35;
      drive($urandom_range(99) < wp, $urandom_range(99) < 50, 8'($urandom));
      clr = ($urandom_range(99) < 5);
      if (i % 50 == 25) begin
        af0 = 6'($urandom_range(32, 1));
        ae0 = 6'($urandom_range(31, 0));
        af1 = 3'($urandom_range(5, 1));
        ae1 = 3'($urandom_range(4, 0));
        #1;
        check_eq("live_s_af", 32'(s_af), 32'(int'(s_count) >= int'(af0)));
        check_eq("live_f_ae", 32'(f_ae), 32'(int'(f_count) <= int'(ae1)));
      end
      tick();
    end
    clr = 1'b0;

    // Mid-stream asynchronous reset at count 7
    for (int i = 0; i < 40; i++) begin drive(1'b0, 1'b1, 8'h00); tick(); end
    for (int i = 0; i < 7; i++) begin drive(1'b1, 1'b0, 8'($urandom)); tick(); end
    check_eq("pre_rst_count", 32'(s_count), 32'd7);
    drive(1'b0, 1'b0, 8'h00);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    check_eq("mid_rst_count", 32'(s_count), 32'd0);
    check_eq("mid_rst_valid", 32'(s_valid), 32'h0);
    check_eq("mid_rst_fovf",  32'(f_ovf),   32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive($urandom_range(1), $urandom_range(1), 8'($urandom));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
